// File: rtl/reg_bank_scan_pkg.sv
// Shared definitions for the register bank scanner and the downstream 4:1 result mux.
package reg_bank_scan_pkg;

  localparam int unsigned N_DEFAULT = 16;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned SEL_W     = 2;

  localparam logic [SEL_W-1:0] SEL_R0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_R1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_R2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_R3 = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/reg_bank_scan_reg_en.sv
// N-bit register with async active-low reset, synchronous clear and load enable.
module reg_en #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear takes priority over load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_scan.sv
// Four-entry register bank with a valid/ready scan sequencer driving the result mux select.
module reg_bank_scan
  import reg_bank_scan_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [SEL_W-1:0] wr_addr,
  input  logic [N-1:0]     wr_data,
  input  logic             clr,
  input  logic             start,
  input  logic             scan_ready,
  output logic             scan_valid,
  output logic             scan_last,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] selecm,
  output logic [N-1:0]     R_0,
  output logic [N-1:0]     R_1,
  output logic [N-1:0]     R_2,
  output logic [N-1:0]     R_3
);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             scan_valid_q, scan_valid_d;
  logic             done_q, done_d;

  logic             idle;
  logic             clr_all;
  logic             wr_fire;
  logic [N-1:0]     r_q [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= SEL_R0;
      scan_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      scan_valid_q <= scan_valid_d;
      done_q       <= done_d;
    end
  end

  // Scan sequencing: one select code per accepted beat, exit on acceptance of the last.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    scan_valid_d = scan_valid_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SCAN;
          idx_d        = SEL_R0;
          scan_valid_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_ready) begin
          if (idx_q == SEL_R3) begin
            state_d      = ST_IDLE;
            idx_d        = SEL_R0;
            scan_valid_d = 1'b0;
            done_d       = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        idx_d        = SEL_R0;
        scan_valid_d = 1'b0;
      end
    endcase
  end

  assign idle    = (state_q == ST_IDLE);
  assign clr_all = idle & clr;
  assign wr_fire = idle & wr_valid;

  // Registers only change in IDLE, so a stalled beat stays stable.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    reg_en #(.W(N)) u_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr_all),
      .en      (wr_fire && (wr_addr == SEL_W'(i))),
      .d       (wr_data),
      .q       (r_q[i])
    );
  end

  assign R_0        = r_q[0];
  assign R_1        = r_q[1];
  assign R_2        = r_q[2];
  assign R_3        = r_q[3];

  assign wr_ready   = idle;
  assign busy       = ~idle;
  assign scan_last  = ~idle && (idx_q == SEL_R3);
  assign scan_valid = scan_valid_q;
  assign done       = done_q;
  assign selecm     = idx_q;

endmodule

// File: tb/tb_reg_bank_scan.sv
// Directed self-checking bench for reg_bank_scan.
module tb_reg_bank_scan;

  localparam int unsigned N = 16;

  logic         clk;
  logic         reset_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [1:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic         clr;
  logic         start;
  logic         scan_ready;
  logic         scan_valid;
  logic         scan_last;
  logic         busy;
  logic         done;
  logic [1:0]   selecm;
  logic [N-1:0] R_0, R_1, R_2, R_3;

  int checks = 0;
  int errors = 0;

  reg_bank_scan #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr        (clr),
    .start      (start),
    .scan_ready (scan_ready),
    .scan_valid (scan_valid),
    .scan_last  (scan_last),
    .busy       (busy),
    .done       (done),
    .selecm     (selecm),
    .R_0        (R_0),
    .R_1        (R_1),
    .R_2        (R_2),
    .R_3        (R_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] reg_val(input int i);
    case (i)
      0: return R_0;
      1: return R_1;
      2: return R_2;
      default: return R_3;
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; wr_valid = 1'b0; wr_addr = 2'd0; wr_data = '0;
    clr = 1'b0; start = 1'b0; scan_ready = 1'b0;
    #12;
    checks++;
    if ({scan_valid, scan_last, busy, done, selecm} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 000000", {scan_valid, scan_last, busy, done, selecm});
    end
    checks++;
    if ({R_0, R_1, R_2, R_3} !== 64'h0) begin
      errors++;
      $display("FAIL reset_regs got %h expected 0", {R_0, R_1, R_2, R_3});
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wr_ready got %b expected 1", wr_ready);
    end
  endtask

  task automatic test_write();
    logic [N-1:0] vals [4];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 2'(i); wr_data = vals[i];
      step();
      checks++;
      if (reg_val(i) !== vals[i]) begin
        errors++;
        $display("FAIL write_r%0d got %h expected %h", i, reg_val(i), vals[i]);
      end
    end
    wr_valid = 1'b0;
    checks++;
    if ({selecm, busy} !== 3'b000) begin
      errors++;
      $display("FAIL write_idle got sel=%b busy=%b expected 00/0", selecm, busy);
    end
  endtask

  task automatic test_scan();
    logic [N-1:0] exp_r [4];
    exp_r[0] = 16'h1111; exp_r[1] = 16'h2222; exp_r[2] = 16'h3333; exp_r[3] = 16'h4444;
    scan_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (selecm !== 2'(i) || scan_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0
          || wr_ready !== 1'b0 || scan_last !== (i == 3)) begin
        errors++;
        $display("FAIL scan_beat%0d got sel=%b v=%b last=%b busy=%b done=%b wr_ready=%b expected sel=%0d v=1 last=%0d busy=1 done=0 wr_ready=0",
                 i, selecm, scan_valid, scan_last, busy, done, wr_ready, i, (i == 3));
      end
      checks++;
      if (reg_val(i) !== exp_r[i]) begin
        errors++;
        $display("FAIL scan_data%0d got %h expected %h", i, reg_val(i), exp_r[i]);
      end
      step();
    end
    checks++;
    if ({done, busy, wr_ready, scan_valid, scan_last} !== 5'b10100) begin
      errors++;
      $display("FAIL scan_done got done,busy,wr_ready,valid,last=%b expected 10100",
               {done, busy, wr_ready, scan_valid, scan_last});
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL scan_done_once got %b expected 0", done);
    end
  endtask

  task automatic test_stall();
    logic [1:0] exp_sel [7];
    logic       rdy     [7];
    exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd1; exp_sel[3] = 2'd1;
    exp_sel[4] = 2'd1; exp_sel[5] = 2'd2; exp_sel[6] = 2'd3;
    rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b0;
    rdy[4] = 1'b1; rdy[5] = 1'b1; rdy[6] = 1'b1;
    scan_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (selecm !== exp_sel[c] || scan_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d got sel=%b v=%b done=%b expected sel=%b v=1 done=0",
                 c, selecm, scan_valid, done, exp_sel[c]);
      end
      scan_ready = rdy[c];
      step();
    end
    checks++;
    if (done !== 1'b1 || scan_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end got done=%b v=%b expected done=1 v=0", done, scan_valid);
    end
    step();
  endtask

  task automatic test_write_during_scan();
    scan_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_ready !== 1'b0 || R_2 !== 16'h3333) begin
        errors++;
        $display("FAIL scanwr_beat%0d got wr_ready=%b R_2=%h expected 0/3333", i, wr_ready, R_2);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || wr_ready !== 1'b1 || R_2 !== 16'h3333) begin
      errors++;
      $display("FAIL scanwr_done got done=%b wr_ready=%b R_2=%h expected 1/1/3333", done, wr_ready, R_2);
    end
    step();
    wr_valid = 1'b0;
    checks++;
    if (R_2 !== 16'hBEEF) begin
      errors++;
      $display("FAIL scanwr_commit got %h expected beef", R_2);
    end
  endtask

  task automatic test_clr_priority();
    bit got_done = 1'b0;
    scan_ready = 1'b1; start = 1'b1; clr = 1'b1;
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 16'hAAAA;
    step();
    start = 1'b0; clr = 1'b0; wr_valid = 1'b0;
    checks++;
    if ({R_0, R_1, R_2, R_3} !== 64'h0) begin
      errors++;
      $display("FAIL clr_regs got %h expected 0", {R_0, R_1, R_2, R_3});
    end
    checks++;
    if (selecm !== 2'd0 || scan_valid !== 1'b1 || R_0 !== 16'h0) begin
      errors++;
      $display("FAIL clr_first_beat got sel=%b v=%b R_0=%h expected 00/1/0000", selecm, scan_valid, R_0);
    end
    for (int c = 0; c < 10 && !got_done; c++) begin
      step();
      got_done = done;
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL clr_scan_timeout got done=0 expected done within 10 cycles");
    end
    step();
  endtask

  task automatic test_reset_mid_scan();
    bit saw_done = 1'b0;
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 16'h5555;
    step();
    wr_valid = 1'b0;
    scan_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (selecm !== 2'd2 || R_1 !== 16'h5555) begin
      errors++;
      $display("FAIL rst_mid_pre got sel=%b R_1=%h expected 10/5555", selecm, R_1);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({scan_valid, scan_last, busy, done, selecm} !== 6'b0 || {R_0, R_1, R_2, R_3} !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got ctrl=%b regs=%h expected 0/0",
               {scan_valid, scan_last, busy, done, selecm}, {R_0, R_1, R_2, R_3});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after got done_seen=%b wr_ready=%b busy=%b expected 0/1/0", saw_done, wr_ready, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (selecm !== 2'(i) || scan_valid !== 1'b1 || reg_val(i) !== 16'h0) begin
        errors++;
        $display("FAIL rst_rescan%0d got sel=%b v=%b data=%h expected %0d/1/0000", i, selecm, scan_valid, reg_val(i), i);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rst_rescan_done got %b expected 1", done);
    end
  endtask

  task automatic test_back_to_back();
    scan_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got done=%b busy=%b expected 1/0", done, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (scan_valid !== 1'b1 || selecm !== 2'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart got v=%b sel=%b busy=%b done=%b expected 1/00/1/0", scan_valid, selecm, busy, done);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done got %b expected 1", done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_scan();
    test_stall();
    test_write_during_scan();
    test_back_to_back();
    test_clr_priority();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
